aes_round_key_packer: RTL

Sits directly downstream of the on-the-fly AES-128 key expansion block, which emits one 32-bit key word per `next` request. This block drives that block's start/next handshake and collects four consecutive words into a 128-bit round key. It presents round keys 0..10 to the iterative cipher datapath over a valid/ready handshake. It stores only one round key (128 bits), which preserves the on-the-fly storage saving.

---
 rtl/aes_round_key_packer_if.sv | 11 +
 rtl/aes_round_key_packer.sv | 108 ++++++++++
 2 files changed

// File: rtl/aes_round_key_packer_if.sv
// rtl/aes_round_key_packer_if.sv - round key stream from the packer to the cipher datapath
interface aes_round_key_packer_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    modport master (output rk_valid, rk_data, rk_round, rk_last, input rk_ready);
    modport slave  (input rk_valid, rk_data, rk_round, rk_last, output rk_ready);
endinterface

// File: rtl/aes_round_key_packer.sv
// rtl/aes_round_key_packer.sv - packs AES-128 key expansion words into 128-bit round keys
// Optional AES_RKP_ADDR_CHECK_EN adds a sticky addr_err check of kx_addr.
module aes_round_key_packer #(
    parameter int RK_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] key_in,
    output logic         kx_start,
    output logic [127:0] kx_key,
    output logic         kx_next,
    input  logic [31:0]  kx_word,
    input  logic [5:0]   kx_addr,
    input  logic         kx_ready,
    aes_round_key_packer_if.master rk,
`ifdef AES_RKP_ADDR_CHECK_EN
    output logic         addr_err,
`endif
    output logic         busy
);
    localparam logic [3:0] LAST_ROUND = 4'(RK_ROUNDS);

    typedef enum logic [1:0] {IDLE, START, FETCH, PRESENT} state_t;

    state_t       state;
    logic [1:0]   slot;
    logic [3:0]   round_q;
    logic [127:0] data_q;
    logic         valid_q;
    logic         capture;

    // kx_next rides on the capture so the expansion advances on the same edge
    assign capture     = (state == FETCH) && kx_ready;
    assign kx_next     = capture;
    assign kx_start    = (state == START);
    assign busy        = (state != IDLE);
    assign rk.rk_valid = valid_q;
    assign rk.rk_data  = data_q;
    assign rk.rk_round = round_q;
    assign rk.rk_last  = valid_q && (round_q == LAST_ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            slot    <= 2'd0;
            round_q <= 4'd0;
            data_q  <= 128'd0;
            valid_q <= 1'b0;
            kx_key  <= 128'd0;
        end else if (load) begin
            // a new load restarts the schedule from any state
            kx_key  <= key_in;
            round_q <= 4'd0;
            slot    <= 2'd0;
            valid_q <= 1'b0;
            state   <= START;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                START: state <= FETCH;
                FETCH: begin
                    if (capture) begin
                        case (slot)
                            2'd0:    data_q[127:96] <= kx_word;
                            2'd1:    data_q[95:64]  <= kx_word;
                            2'd2:    data_q[63:32]  <= kx_word;
                            default: data_q[31:0]   <= kx_word;
                        endcase
                        slot <= slot + 2'd1;
                        if (slot == 2'd3) begin
                            valid_q <= 1'b1;
                            state   <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (rk.rk_ready) begin
                        valid_q <= 1'b0;
                        if (round_q == LAST_ROUND) begin
                            state <= IDLE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state   <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_RKP_ADDR_CHECK_EN
    // expected word index is round*4+slot, i.e. {round, slot}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (load) begin
            addr_err <= 1'b0;
        end else if (capture && (kx_addr != {round_q, slot})) begin
            addr_err <= 1'b1;
        end
    end
`else
    logic unused_kx_addr;
    assign unused_kx_addr = ^kx_addr;
`endif
endmodule
